// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode constants and FSM state encoding for calc_arbiter
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bit 2 swaps the operand roles, bit 1 selects abs of the second operand.
  localparam logic [2:0] OP_A_ADD_B  = 3'b000;
  localparam logic [2:0] OP_A_SUB_B  = 3'b001;
  localparam logic [2:0] OP_B_ADD_A  = 3'b100;
  localparam logic [2:0] OP_B_SUB_A  = 3'b101;
  localparam int         OP_SWAP_BIT = 2;
  localparam int         OP_ABS_BIT  = 1;

endpackage

// File: rtl/CombCalc.sv
// rtl/CombCalc.sv - combinational add/sub/abs datapath built around a single adder
module CombCalc
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         ovf
);

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] p;
  logic [W-1:0] q;
  logic         cin;
  logic         is_abs;
  logic         is_sub;

  always_comb begin
    is_abs = op[OP_ABS_BIT];
    is_sub = (op == OP_A_SUB_B) || (op == OP_B_SUB_A);
    x      = op[OP_SWAP_BIT] ? b : a;
    y      = op[OP_SWAP_BIT] ? a : b;
    // abs(y) is 0 + (~y) + 1 for negative y, so it shares the subtract path
    if (is_abs) begin
      p   = '0;
      q   = y[W-1] ? ~y : y;
      cin = y[W-1];
    end else begin
      p   = x;
      q   = is_sub ? ~y : y;
      cin = is_sub;
    end
    r   = p + q + {{(W-1){1'b0}}, cin};
    ovf = (p[W-1] == q[W-1]) && (r[W-1] != p[W-1]);
  end

endmodule

// File: rtl/calc_arbiter.sv
// rtl/calc_arbiter.sv - two-requester round-robin front end for a single CombCalc
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [2:0]   req0_op,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_r,
  output logic         rsp_ovf,
  output logic [7:0]   ovf_count,
  input  logic         ovf_clr
);

  state_t       state;
  logic         pri;
  logic         cur_id;
  logic [2:0]   cur_op;
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;
  logic         any_valid;
  logic         grant_id;
  logic         accept;
  logic [W-1:0] calc_r;
  logic         calc_ovf;

  always_comb begin
    any_valid = req0_valid || req1_valid;
    grant_id  = (req0_valid && req1_valid) ? pri : req1_valid;
    accept    = rst_n && (state == ST_IDLE) && any_valid;
  end

  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  CombCalc #(
    .W(W)
  ) u_calc (
    .op (cur_op),
    .a  (cur_a),
    .b  (cur_b),
    .r  (calc_r),
    .ovf(calc_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pri       <= 1'b0;
      cur_id    <= 1'b0;
      cur_op    <= '0;
      cur_a     <= '0;
      cur_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= 1'b0;
      ovf_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_valid) begin
            cur_id <= grant_id;
            cur_op <= grant_id ? req1_op : req0_op;
            cur_a  <= grant_id ? req1_a : req0_a;
            cur_b  <= grant_id ? req1_b : req0_b;
            pri    <= ~grant_id;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_r     <= calc_r;
          rsp_ovf   <= calc_ovf;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Clear takes precedence over a same-cycle increment.
      if (ovf_clr) begin
        ovf_count <= '0;
      end else if ((state == ST_EXEC) && calc_ovf && (ovf_count != 8'hFF)) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// tb/tb_calc_arbiter.sv - directed and randomized self-checking bench for calc_arbiter
module tb_calc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [15:0] rsp_r;
  logic        rsp_ovf;
  logic [7:0]  ovf_count;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  calc_arbiter #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_ovf(rsp_ovf), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Ideal result: exact integer arithmetic, then wrap to 16 bits; overflow when out of range.
  function automatic longint ideal(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (op)
      3'b000: return x + y;
      3'b001: return x - y;
      3'b010, 3'b011: return (y < 0) ? -y : y;
      3'b100: return y + x;
      3'b101: return y - x;
      default: return (x < 0) ? -x : x;
    endcase
  endfunction

  function automatic logic [15:0] exp_r(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    longint f;
    f = ideal(op, a, b);
    return f[15:0];
  endfunction

  function automatic logic exp_ovf(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    longint f;
    f = ideal(op, a, b);
    return (f > 32767) || (f < -32768);
  endfunction

  // Reference model: phase 0 waiting, 1 computing, 2 presenting a response.
  int          m_phase = 0;
  bit          m_pri = 1'b0;
  int          m_cnt = 0;
  bit          m_rv = 1'b0, m_ro = 1'b0, m_rid = 1'b0, m_id = 1'b0;
  logic [15:0] m_rr = '0, m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0;
  bit          m_acc0 = 1'b0, m_acc1 = 1'b0;

  function automatic bit model_grant();
    return (req0_valid && req1_valid) ? m_pri : req1_valid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_pri <= 1'b0; m_cnt <= 0; m_rv <= 1'b0;
      m_rr <= '0; m_ro <= 1'b0; m_rid <= 1'b0; m_acc0 <= 1'b0; m_acc1 <= 1'b0;
    end else begin
      m_acc0 <= 1'b0;
      m_acc1 <= 1'b0;
      if (ovf_clr) m_cnt <= 0;
      if (m_phase == 0 && (req0_valid || req1_valid)) begin
        m_id  <= model_grant();
        m_pri <= !model_grant();
        m_op  <= model_grant() ? req1_op : req0_op;
        m_a   <= model_grant() ? req1_a : req0_a;
        m_b   <= model_grant() ? req1_b : req0_b;
        if (model_grant()) m_acc1 <= 1'b1; else m_acc0 <= 1'b1;
        m_phase <= 1;
      end else if (m_phase == 1) begin
        m_rr  <= exp_r(m_op, m_a, m_b);
        m_ro  <= exp_ovf(m_op, m_a, m_b);
        m_rid <= m_id;
        m_rv  <= 1'b1;
        if (!ovf_clr && exp_ovf(m_op, m_a, m_b) && m_cnt < 255) m_cnt <= m_cnt + 1;
        m_phase <= 2;
      end else if (m_phase == 2 && rsp_ready) begin
        m_rv    <= 1'b0;
        m_phase <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req0_ready", 32'(req0_ready),
          32'(rst_n && m_phase == 0 && (req0_valid || req1_valid) && !model_grant()));
      chk("req1_ready", 32'(req1_ready),
          32'(rst_n && m_phase == 0 && (req0_valid || req1_valid) && model_grant()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("rsp_r", 32'(rsp_r), 32'(m_rr));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(m_ro));
        chk("rsp_id", 32'(rsp_id), 32'(m_rid));
      end
      chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input bit id);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (id ? m_acc1 : m_acc0) begin
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic present(input bit id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic issue(input bit id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    present(id, op, a, b);
    wait_acc(id);
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    chk("resp_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_r", 32'(rsp_r), 32'd0);
    chk("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_ovf_count", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 0x7FFF + 1 wraps to 0x8000 with overflow
    rsp_ready = 1'b1;
    issue(1'b0, 3'b000, 16'h7FFF, 16'h0001);
    chk("latency_exec", 32'(rsp_valid), 32'd0);
    tick();
    chk("latency_resp", 32'(rsp_valid), 32'd1);
    chk("add_ovf_r", 32'(rsp_r), 32'h8000);
    chk("add_ovf_flag", 32'(rsp_ovf), 32'd1);
    chk("add_ovf_id", 32'(rsp_id), 32'd0);
    chk("add_ovf_count", 32'(ovf_count), 32'd1);
    tick();

    // both requesters pending out of reset
    rst_n = 1'b0;
    present(1'b0, 3'b001, 16'd10, 16'd3);
    present(1'b1, 3'b110, 16'hFFFB, 16'd0);
    tick();
    rst_n = 1'b1;
    wait_acc(1'b0);
    wait_resp();
    chk("rr_first_r", 32'(rsp_r), 32'd7);
    chk("rr_first_id", 32'(rsp_id), 32'd0);
    wait_acc(1'b1);
    wait_resp();
    chk("rr_second_r", 32'(rsp_r), 32'd5);
    chk("rr_second_ovf", 32'(rsp_ovf), 32'd0);
    chk("rr_second_id", 32'(rsp_id), 32'd1);
    tick();

    // back-pressure: response held for five cycles
    rsp_ready = 1'b0;
    issue(1'b1, 3'b100, 16'd3, 16'd4);
    present(1'b0, 3'b000, 16'd1, 16'd1);
    tick();
    repeat (5) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_r", 32'(rsp_r), 32'd7);
      chk("hold_id", 32'(rsp_id), 32'd1);
      chk("hold_ready0", 32'(req0_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("release_idle_ready0", 32'(req0_ready), 32'd1);
    wait_acc(1'b0);
    wait_resp();
    tick();

    // reset while a command is computing
    issue(1'b0, 3'b000, 16'h7FFF, 16'h0001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("reset_drop_valid", 32'(rsp_valid), 32'd0);
    end
    chk("reset_drop_count", 32'(ovf_count), 32'd0);
    present(1'b0, 3'b000, 16'd2, 16'd2);
    present(1'b1, 3'b000, 16'd5, 16'd5);
    #1;
    chk("reset_pri_ready0", 32'(req0_ready), 32'd1);
    chk("reset_pri_ready1", 32'(req1_ready), 32'd0);
    wait_acc(1'b0);
    wait_acc(1'b1);
    wait_resp();
    tick();

    // saturation and clear-wins
    for (int i = 0; i < 300; i++) issue(1'b0, (i % 2 == 0) ? 3'b110 : 3'b111, 16'h8000, 16'($urandom));
    wait_resp();
    chk("abs_min_r", 32'(rsp_r), 32'h8000);
    tick();
    chk("sat_count", 32'(ovf_count), 32'd255);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_count", 32'(ovf_count), 32'd0);
    repeat (3) issue(1'b1, 3'b101, 16'h0001, 16'h8000);
    tick();
    tick();
    chk("count_three", 32'(ovf_count), 32'd3);
    issue(1'b0, 3'b000, 16'h8000, 16'hFFFF);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_wins", 32'(ovf_count), 32'd0);
    chk("clr_wins_ovf", 32'(rsp_ovf), 32'd1);
    tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (!req0_valid || m_acc0) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_op = 3'($urandom); req0_a = rnd_operand(); req0_b = rnd_operand();
      end
      if (!req1_valid || m_acc1) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_op = 3'($urandom); req1_a = rnd_operand(); req1_b = rnd_operand();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 60) == 0);
      rst_n = ($urandom_range(0, 500) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
